// File: rtl/itcm_arbiter_if.sv
// Bus bundle between the core-side requesters / ITCM macro and the arbiter.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface itcm_arbiter_if #(
    parameter int AW = 10
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;

    logic          ls_req;
    logic          ls_we;
    logic [3:0]    ls_be;
    logic [AW-1:0] ls_addr;
    logic [31:0]   ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [31:0]   ls_rdata;

    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/itcm_arbiter.sv
// Single-port ITCM arbiter: IF has priority, LS is force-granted after STARVE_MAX
// consecutive denied cycles. Combinational grant, fixed 1-cycle response.
module itcm_arbiter #(
    parameter int AW         = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    itcm_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    // LS writes are tracked separately so their ack never carries SRAM read data.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_IF    = 2'd1,
        OWN_LS_RD = 2'd2,
        OWN_LS_WR = 2'd3
    } owner_t;

    owner_t        owner_r;
    owner_t        owner_nxt_s;
    logic [3:0]    starve_r;
    logic [3:0]    starve_nxt_s;
    logic          if_gnt_s;
    logic          ls_gnt_s;
    logic          mem_en_s;
    logic [3:0]    mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [31:0]   mem_wdata_s;
    logic          if_rvalid_s;
    logic          ls_rvalid_s;
    logic [31:0]   if_rdata_s;
    logic [31:0]   ls_rdata_s;

    // Grant selection: IF priority unless LS has hit the starvation limit.
    always_comb begin
        if_gnt_s = 1'b0;
        ls_gnt_s = 1'b0;
        if (rst) begin
            if_gnt_s = 1'b0;
            ls_gnt_s = 1'b0;
        end else if (bus.if_req && bus.ls_req) begin
            if (starve_r == STARVE_LIM) begin
                ls_gnt_s = 1'b1;
            end else begin
                if_gnt_s = 1'b1;
            end
        end else if (bus.if_req) begin
            if_gnt_s = 1'b1;
        end else if (bus.ls_req) begin
            ls_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
            ls_gnt_s = 1'b0;
        end
    end

    // SRAM command mux driven from the granted port.
    always_comb begin
        mem_en_s    = if_gnt_s | ls_gnt_s;
        mem_we_s    = 4'b0000;
        mem_addr_s  = bus.if_addr;
        mem_wdata_s = 32'h0000_0000;
        if (ls_gnt_s) begin
            mem_addr_s  = bus.ls_addr;
            mem_wdata_s = bus.ls_wdata;
            mem_we_s    = bus.ls_we ? bus.ls_be : 4'b0000;
        end else begin
            mem_addr_s  = bus.if_addr;
            mem_wdata_s = 32'h0000_0000;
            mem_we_s    = 4'b0000;
        end
    end

    // Next owner and starvation counter (saturating, cleared when LS is served or idle).
    always_comb begin
        owner_nxt_s  = OWN_NONE;
        starve_nxt_s = 4'd0;
        if (if_gnt_s) begin
            owner_nxt_s = OWN_IF;
        end else if (ls_gnt_s) begin
            owner_nxt_s = bus.ls_we ? OWN_LS_WR : OWN_LS_RD;
        end else begin
            owner_nxt_s = OWN_NONE;
        end
        if (bus.ls_req && !ls_gnt_s) begin
            if (starve_r < STARVE_LIM) begin
                starve_nxt_s = starve_r + 4'd1;
            end else begin
                starve_nxt_s = starve_r;
            end
        end else begin
            starve_nxt_s = 4'd0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r  <= OWN_NONE;
            starve_r <= 4'd0;
        end else begin
            owner_r  <= owner_nxt_s;
            starve_r <= starve_nxt_s;
        end
    end

    // Response decode; reset kills any response still in flight.
    always_comb begin
        if_rvalid_s = 1'b0;
        ls_rvalid_s = 1'b0;
        if_rdata_s  = 32'h0000_0000;
        ls_rdata_s  = 32'h0000_0000;
        if (rst) begin
            if_rvalid_s = 1'b0;
            ls_rvalid_s = 1'b0;
        end else begin
            case (owner_r)
                OWN_IF: begin
                    if_rvalid_s = 1'b1;
                    if_rdata_s  = bus.mem_rdata;
                end
                OWN_LS_RD: begin
                    ls_rvalid_s = 1'b1;
                    ls_rdata_s  = bus.mem_rdata;
                end
                OWN_LS_WR: begin
                    ls_rvalid_s = 1'b1;
                end
                default: begin
                    if_rvalid_s = 1'b0;
                    ls_rvalid_s = 1'b0;
                end
            endcase
        end
    end

    assign bus.if_gnt    = if_gnt_s;
    assign bus.ls_gnt    = ls_gnt_s;
    assign bus.mem_en    = mem_en_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.if_rvalid = if_rvalid_s;
    assign bus.ls_rvalid = ls_rvalid_s;
    assign bus.if_rdata  = if_rdata_s;
    assign bus.ls_rdata  = ls_rdata_s;
endmodule
